seqrec_param: RTL and testbench
===============================

SEQREC_PARAM -- requirements
Module: seqrec_param

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_DEFAULT, default 4'b1011 (width PAT_LEN): pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8: match-counter width.
REQ-004 Port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port RST  input  1  reset, synchronous, active-low.
REQ-006 Port x  input  1  serial data bit, sampled on the CLK rising edge.
REQ-007 Port en  input  1  bit-accept enable; x is ignored when low.
REQ-008 Port ovl  input  1  mode select: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port pat_load  input  1  load pat_in into the pattern register.
REQ-010 Port pat_in  input  PAT_LEN  new pattern; MSB is the first-received bit.
REQ-011 Port clr_cnt  input  1  clear the match counter.
REQ-012 Port y  output  1  registered match pulse.
REQ-013 Port count  output  CNT_W  saturating match count.
REQ-014 Port armed  output  1  high when at least PAT_LEN-1 bits have been accepted since the last clear.

Function
REQ-015 The block SHALL keep a history register of the last PAT_LEN-1 accepted bits, newest in the LSB, plus a fill counter that saturates at PAT_LEN-1.
REQ-016 An accepted bit is x sampled on an edge with en=1 and pat_load=0.
REQ-017 A match SHALL occur on an accepted bit when fill = PAT_LEN-1 and {history, x} equals the pattern register.
REQ-018 y SHALL be 1 for exactly the one cycle after the edge that sampled the completing bit; otherwise 0, including every cycle with en=0.
REQ-019 Overlapping mode: after a match, history and fill update normally, so the match's trailing bits may begin the next match.
REQ-020 Non-overlapping mode: on a match, fill SHALL clear to 0 and the history SHALL be treated as empty.
REQ-021 A change of ovl SHALL take effect on the next accepted bit.
REQ-022 With en=0, history, fill and count SHALL hold.
REQ-023 pat_load=1 SHALL load pat_in, clear history and fill, and force y=0 on that edge; it takes precedence over en.
REQ-024 count SHALL increment by 1 per match and saturate at 2^CNT_W-1 (no wrap).
REQ-025 clr_cnt=1 SHALL set count to 0; when a match occurs on the same edge, the clear wins and count=0.
REQ-026 clr_cnt SHALL NOT affect history, fill, pattern or y.
REQ-027 armed SHALL be a registered value equal to (fill = PAT_LEN-1).

Reset
REQ-028 When RST=0 at a rising edge: y=0, count=0, armed=0, history=0, fill=0, pattern=PAT_DEFAULT.
REQ-029 Reset SHALL override en, pat_load and clr_cnt, and abort any partial match; detection restarts from an empty history once RST=1.

Structure
REQ-030 Package seqrec_pkg SHALL hold the default constants (PAT_LEN, CNT_W, PAT_DEFAULT) and the fill-counter width derived as clog2(PAT_LEN).
REQ-031 The saturating counter SHALL be a sub-module, seqrec_sat_cnt (parameter CNT_W; inputs inc and clr, clr dominant).
REQ-032 Total RTL SHALL be 120-400 lines, synthesizable, with no latches.

Verification
REQ-033 Overlap: defaults, ovl=1, en=1, stream 010110101101100 (MSB first) -> y pulses after bits 4, 9 and 12 (0-indexed), count=3.
REQ-034 Non-overlap: same stream, ovl=0 -> y pulses after bits 4 and 9 only, count=2.
REQ-035 Load and gating: pat_load with pat_in=4'b1101, then the same stream with en dropped for 3 cycles between bits 7 and 8 -> pulses after bits 6 and 11 only, no pulse while en=0, count=2.
REQ-036 Saturation and clear: CNT_W=2, 5 matches -> count=3; clr_cnt asserted on a match edge -> count=0, y=1.
REQ-037 Reset mid-pattern: after 101, assert RST=0 for 1 cycle, then send 1 -> no pulse, armed=0; next 1011 -> a single pulse.

Source files
------------

// File: rtl/seqrec_pkg.sv
// Shared constants for the serial pattern recogniser.
//   DEF_PAT_LEN / DEF_CNT_W / DEF_PAT_DEFAULT : default parameter values
//   DEF_FILL_W                                : fill-counter width for the default length
//   fill_width()                              : fill-counter width for any pattern length
package seqrec_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PAT_DEFAULT = 4'b1011;

  // Fill saturates at PAT_LEN-1, so clog2(PAT_LEN) bits always suffice.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len);
  endfunction

  localparam int unsigned DEF_FILL_W = fill_width(DEF_PAT_LEN);

endpackage

// File: rtl/seqrec_sat_cnt.sv
// Saturating up-counter with dominant synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : count up by one (held at all-ones)
//   clr        : force to zero, wins over inc
//   count      : registered count value
module seqrec_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seqrec_param.sv
// Serial pattern recogniser with loadable pattern, overlap/non-overlap modes
// and a saturating match counter.
//   CLK, RST   : clock, synchronous active-low reset
//   x, en      : serial data bit and its accept enable
//   ovl        : 1 = overlapping, 0 = non-overlapping detection
//   pat_load   : load pat_in (MSB = first bit) and restart detection
//   clr_cnt    : clear the match counter
//   y          : one-cycle match pulse
//   count      : saturating number of matches
//   armed      : PAT_LEN-1 bits collected, next bit can complete a match
module seqrec_param
  import seqrec_pkg::*;
#(
  parameter int unsigned           PAT_LEN     = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]    PAT_DEFAULT = PAT_LEN'(DEF_PAT_DEFAULT),
  parameter int unsigned           CNT_W       = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               x,
  input  logic               en,
  input  logic               ovl,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   count,
  output logic               armed
);

  localparam int unsigned         HIST_W   = PAT_LEN - 1;
  localparam int unsigned         FILL_W   = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q,  pat_n;
  logic [HIST_W-1:0]  hist_q, hist_n;
  logic [FILL_W-1:0]  fill_q, fill_n;
  logic               accept_c;
  logic               match_c;

  // Next-state for pattern, history and fill; pat_load outranks a data bit.
  always_comb begin
    accept_c = en & ~pat_load;
    match_c  = accept_c && (fill_q == FILL_MAX) && ({hist_q, x} == pat_q);
    pat_n    = pat_q;
    hist_n   = hist_q;
    fill_n   = fill_q;
    if (pat_load) begin
      pat_n  = pat_in;
      hist_n = '0;
      fill_n = '0;
    end else if (accept_c) begin
      if (match_c && !ovl) begin
        // Non-overlapping: the matched bits cannot start the next match.
        hist_n = '0;
        fill_n = '0;
      end else begin
        hist_n = HIST_W'({hist_q, x});
        if (fill_q != FILL_MAX) begin
          fill_n = fill_q + FILL_W'(1);
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pat_q  <= PAT_DEFAULT;
      hist_q <= '0;
      fill_q <= '0;
      y      <= 1'b0;
      armed  <= 1'b0;
    end else begin
      pat_q  <= pat_n;
      hist_q <= hist_n;
      fill_q <= fill_n;
      y      <= match_c;
      armed  <= (fill_n == FILL_MAX);
    end
  end

  seqrec_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (match_c),
    .clr   (clr_cnt),
    .count (count)
  );

endmodule

// File: tb/tb_seqrec_param.sv
// Directed bench for seqrec_param: a default-width instance plus a 2-bit
// counter instance sharing the same stimulus.
module tb_seqrec_param;

  logic       CLK = 1'b0;
  logic       RST, x, en, ovl, pat_load, clr_cnt;
  logic [3:0] pat_in;
  logic       y, armed, y2, armed2;
  logic [7:0] count;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seqrec_param u_dut (
    .CLK (CLK), .RST (RST), .x (x), .en (en), .ovl (ovl),
    .pat_load (pat_load), .pat_in (pat_in), .clr_cnt (clr_cnt),
    .y (y), .count (count), .armed (armed)
  );

  seqrec_param #(.CNT_W(2)) u_sat (
    .CLK (CLK), .RST (RST), .x (x), .en (en), .ovl (ovl),
    .pat_load (pat_load), .pat_in (pat_in), .clr_cnt (clr_cnt),
    .y (y2), .count (count2), .armed (armed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are read there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; en = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0; x = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic send(input logic b, input logic ey, input string tag);
    x  = b;
    en = 1'b1;
    tick();
    chk(tag, {31'd0, y}, {31'd0, ey});
  endtask

  logic [14:0] stream;
  logic [14:0] exp_y;

  initial begin
    RST = 1'b0; x = 1'b0; en = 1'b0; ovl = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; clr_cnt = 1'b0;
    stream = 15'b010110101101100;

    // Reset state
    do_reset();
    chk("rst_y", {31'd0, y}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);

    // Overlapping: pulses after bits 4, 9, 12
    ovl   = 1'b1;
    exp_y = 15'b000010000100100;
    for (int i = 0; i < 15; i++) begin
      send(stream[14-i], exp_y[14-i], $sformatf("ovl_bit%0d", i));
      if (i == 1) chk("ovl_armed_lo", {31'd0, armed}, 32'd0);
      if (i == 2) chk("ovl_armed_hi", {31'd0, armed}, 32'd1);
    end
    en = 1'b0;
    tick();
    chk("ovl_idle_y", {31'd0, y}, 32'd0);
    chk("ovl_count", {24'd0, count}, 32'd3);

    // Non-overlapping: pulses after bits 4, 9 only
    do_reset();
    ovl   = 1'b0;
    exp_y = 15'b000010000100000;
    for (int i = 0; i < 15; i++) begin
      send(stream[14-i], exp_y[14-i], $sformatf("novl_bit%0d", i));
    end
    en = 1'b0;
    tick();
    chk("novl_count", {24'd0, count}, 32'd2);

    // Pattern load, then gated stream: pulses after bits 6, 11
    do_reset();
    ovl = 1'b1;
    // Arm on default pattern first; the load edge must still give y=0.
    send(1'b1, 1'b0, "ld_pre0");
    send(1'b0, 1'b0, "ld_pre1");
    send(1'b1, 1'b0, "ld_pre2");
    x = 1'b1; en = 1'b1; pat_load = 1'b1; pat_in = 4'b1101;
    tick();
    pat_load = 1'b0;
    chk("ld_y", {31'd0, y}, 32'd0);
    chk("ld_armed", {31'd0, armed}, 32'd0);
    chk("ld_count", {24'd0, count}, 32'd0);
    exp_y = 15'b000000100001000;
    for (int i = 0; i < 15; i++) begin
      if (i == 8) begin
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          x = ~x;
          tick();
          chk($sformatf("gate_y%0d", k), {31'd0, y}, 32'd0);
          chk($sformatf("gate_armed%0d", k), {31'd0, armed}, 32'd1);
        end
      end
      send(stream[14-i], exp_y[14-i], $sformatf("ld_bit%0d", i));
    end
    en = 1'b0;
    tick();
    chk("ld_count_end", {24'd0, count}, 32'd2);

    // Saturation (2-bit counter) and clear on a match edge
    do_reset();
    ovl = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b0, $sformatf("sat%0d_b0", k));
      send(1'b0, 1'b0, $sformatf("sat%0d_b1", k));
      send(1'b1, 1'b0, $sformatf("sat%0d_b2", k));
      send(1'b1, 1'b1, $sformatf("sat%0d_b3", k));
    end
    chk("sat_count8", {24'd0, count}, 32'd5);
    chk("sat_count2", {30'd0, count2}, 32'd3);
    send(1'b1, 1'b0, "clr_b0");
    send(1'b0, 1'b0, "clr_b1");
    send(1'b1, 1'b0, "clr_b2");
    clr_cnt = 1'b1;
    send(1'b1, 1'b1, "clr_match_y");
    clr_cnt = 1'b0;
    chk("clr_count8", {24'd0, count}, 32'd0);
    chk("clr_count2", {30'd0, count2}, 32'd0);
    chk("clr_y2", {31'd0, y2}, 32'd1);

    // Reset mid-pattern aborts the partial match
    do_reset();
    ovl = 1'b1;
    send(1'b1, 1'b0, "mid_b0");
    send(1'b0, 1'b0, "mid_b1");
    send(1'b1, 1'b0, "mid_b2");
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("mid_rst_armed", {31'd0, armed}, 32'd0);
    send(1'b1, 1'b0, "mid_after_rst");
    chk("mid_armed", {31'd0, armed}, 32'd0);
    send(1'b1, 1'b0, "mid_p0");
    send(1'b0, 1'b0, "mid_p1");
    send(1'b1, 1'b0, "mid_p2");
    send(1'b1, 1'b1, "mid_p3");
    en = 1'b0;
    tick();
    chk("mid_y_off", {31'd0, y}, 32'd0);
    chk("mid_count", {24'd0, count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
